// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundle of read, write and reservation signals for regfile_mp.
//   master : drives read addresses/enable, both write ports and the reservation
//            port; observes read data, read busy bits and busy count.
//   slave  : the register file side of the same signals.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output rd_en, rd_addr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_en, rd_addr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with per-register busy scoreboard.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-high reset, clears contents, busy bits, outputs
//   bus   : regfile_mp_if slave -- NUM_RD registered read ports (rd_en gated),
//           ALU write port wr0, load write port wr1 (wr1 wins on a collision),
//           reservation port rsv (sets busy), registered busy_cnt.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          reset,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [DEPTH-1:0]         busy_nxt;
  logic [DEPTH-1:0]         clr;
  logic [DEPTH-1:0]         set;
  logic                     wr0_ok;
  logic                     wr1_ok;
  logic                     rsv_ok;
  logic                     inc;
  logic                     dec0;
  logic                     dec1;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_nxt;
  logic [ADDR_W-1:0]        ra;
  logic [DATA_W-1:0]        rv;
  logic [NUM_RD*DATA_W-1:0] rd_data_nxt;
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]        rd_busy_nxt;
  logic [NUM_RD-1:0]        rd_busy_q;

  // True when the address is the hardwired-zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
  endfunction

  // Register 0 swallows writes and reservations when hardwired.
  assign wr0_ok = bus.wr0_en & ~is_zero(bus.wr0_addr);
  assign wr1_ok = bus.wr1_en & ~is_zero(bus.wr1_addr);
  assign rsv_ok = bus.rsv_en & ~is_zero(bus.rsv_addr);

  // Per-address clear/set decode; a reservation overrides a same-edge writeback.
  always_comb begin
    clr = {DEPTH{1'b0}};
    set = {DEPTH{1'b0}};
    for (int a = 0; a < DEPTH; a++) begin
      clr[a] = (wr0_ok && (bus.wr0_addr == ADDR_W'(a))) ||
               (wr1_ok && (bus.wr1_addr == ADDR_W'(a)));
      set[a] = rsv_ok && (bus.rsv_addr == ADDR_W'(a));
    end
    busy_nxt = (busy & ~clr) | set;
  end

  // Incremental busy count: one possible rise, up to two distinct falls.
  // A fall is suppressed when the same edge re-reserves the address, and wr1
  // does not count again when it hits the same address as wr0.
  always_comb begin
    inc     = rsv_ok & ~busy[bus.rsv_addr];
    dec0    = wr0_ok & busy[bus.wr0_addr] & ~set[bus.wr0_addr];
    dec1    = wr1_ok & busy[bus.wr1_addr] & ~set[bus.wr1_addr] &
              ~(wr0_ok && (bus.wr0_addr == bus.wr1_addr));
    cnt_nxt = cnt + CNT_W'(inc) - CNT_W'(dec0) - CNT_W'(dec1);
  end

  // Read-port next values; bypass picks wr1 before wr0 to match storage order.
  always_comb begin
    rd_data_nxt = {(NUM_RD*DATA_W){1'b0}};
    rd_busy_nxt = {NUM_RD{1'b0}};
    ra          = {ADDR_W{1'b0}};
    rv          = {DATA_W{1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
      if (is_zero(ra)) begin
        rv = {DATA_W{1'b0}};
      end else if ((BYPASS != 0) && wr1_ok && (bus.wr1_addr == ra)) begin
        rv = bus.wr1_data;
      end else if ((BYPASS != 0) && wr0_ok && (bus.wr0_addr == ra)) begin
        rv = bus.wr0_data;
      end else begin
        rv = mem[ra];
      end
      rd_data_nxt[p*DATA_W +: DATA_W] = rv;
      rd_busy_nxt[p]                  = busy_nxt[ra];
    end
  end

  // Storage array; wr1 is assigned last so it wins on a shared address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr0_ok) begin
        mem[bus.wr0_addr] <= bus.wr0_data;
      end
      if (wr1_ok) begin
        mem[bus.wr1_addr] <= bus.wr1_data;
      end
    end
  end

  // Busy bits, busy count and registered read outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= {DEPTH{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      rd_data_q <= {(NUM_RD*DATA_W){1'b0}};
      rd_busy_q <= {NUM_RD{1'b0}};
    end else begin
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
      if (bus.rd_en) begin
        rd_data_q <= rd_data_nxt;
        rd_busy_q <= rd_busy_nxt;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_busy  = rd_busy_q;
  assign bus.busy_cnt = cnt;
endmodule
